// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: parametrised VGA timing and test-pattern generator.
// All timing runs from the single pixel clock. Every output is registered,
// one clock behind the h/v counters, so all outputs stay mutually aligned.
// Pattern requests on the asynchronous sel input are synchronised and
// counted as pending, then applied only at a frame boundary.
// Optional feature macro: VGA_PAT_CHECKER_EN adds pattern 4 (checkerboard).
module vga_pattern_gen #(
    parameter int H_DISPLAY  = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_DISPLAY  = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter int COLOR_W    = 2,
    parameter int SYNC_POL   = 0,
    parameter int CHECK_LOG2 = 3
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               sel,
    output logic               hs,
    output logic               vs,
    output logic               blank_n,
    output logic [COLOR_W-1:0] r,
    output logic [COLOR_W-1:0] g,
    output logic [COLOR_W-1:0] b,
    output logic               frame_start,
    output logic [2:0]         pattern
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT_END  = HW'(H_DISPLAY);
    localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_DISPLAY + H_FRONT);
    localparam logic [HW-1:0] H_SYNC_END = HW'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT_END  = VW'(V_DISPLAY);
    localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_DISPLAY + V_FRONT);
    localparam logic [VW-1:0] V_SYNC_END = VW'(V_DISPLAY + V_FRONT + V_SYNC);

    // Last position inside a gray band / colour bar (band width minus one).
    localparam logic [HW-1:0] GRAY_LAST = HW'(H_DISPLAY / (2 ** COLOR_W) - 1);
    localparam logic [HW-1:0] BAR_LAST  = HW'(H_DISPLAY / 8 - 1);

    localparam logic [COLOR_W-1:0] MAXV     = {COLOR_W{1'b1}};
    localparam logic               POL_HIGH = (SYNC_POL != 0);

`ifdef VGA_PAT_CHECKER_EN
    localparam logic [2:0] LAST_PAT = 3'd4;
`else
    localparam logic [2:0] LAST_PAT = 3'd3;
`endif

    logic [HW-1:0]      h_cnt;
    logic [VW-1:0]      v_cnt;
    logic               line_end;
    logic               frame_end;

    logic [HW-1:0]      gray_pos;
    logic [COLOR_W-1:0] gray_idx;
    logic [HW-1:0]      bar_pos;
    logic [2:0]         bar_idx;

    logic               sel_meta;
    logic               sel_sync;
    logic               sel_prev;
    logic [2:0]         arm;
    logic               sel_edge;
    logic [2:0]         pending;
    logic [2:0]         pending_nxt;
    logic [2:0]         pat_active;

    logic               active;
    logic               in_hs;
    logic               in_vs;
    logic [COLOR_W-1:0] pix_r;
    logic [COLOR_W-1:0] pix_g;
    logic [COLOR_W-1:0] pix_b;

    assign line_end  = (h_cnt == H_LAST);
    assign frame_end = line_end && (v_cnt == V_LAST);

    // Horizontal and vertical position counters, both on the pixel clock.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (line_end) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    // Band trackers: follow h_cnt so band index never needs a divider.
    // They restart together with h_cnt; values past the active region are
    // don't-care because colour is forced to zero there.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            gray_pos <= '0;
            gray_idx <= '0;
            bar_pos  <= '0;
            bar_idx  <= '0;
        end else if (line_end) begin
            gray_pos <= '0;
            gray_idx <= '0;
            bar_pos  <= '0;
            bar_idx  <= '0;
        end else begin
            if (gray_pos == GRAY_LAST) begin
                gray_pos <= '0;
                gray_idx <= gray_idx + 1'b1;
            end else begin
                gray_pos <= gray_pos + 1'b1;
            end
            if (bar_pos == BAR_LAST) begin
                bar_pos <= '0;
                bar_idx <= bar_idx + 1'b1;
            end else begin
                bar_pos <= bar_pos + 1'b1;
            end
        end
    end

    // sel synchroniser and edge history. arm fills with ones after reset so
    // an edge is only counted once sel_prev holds a real sample of sel; a
    // level already high at reset release is therefore never counted.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sel_meta <= 1'b0;
            sel_sync <= 1'b0;
            sel_prev <= 1'b0;
            arm      <= '0;
        end else begin
            sel_meta <= sel;
            sel_sync <= sel_meta;
            sel_prev <= sel_sync;
            arm      <= {arm[1:0], 1'b1};
        end
    end

    assign sel_edge = arm[2] & sel_sync & ~sel_prev;

    // Next pending index: advance on each detected edge, wrap after the last.
    always_comb begin
        pending_nxt = pending;
        if (sel_edge) begin
            pending_nxt = (pending == LAST_PAT) ? 3'd0 : pending + 3'd1;
        end
    end

    // Pending index register; the active pattern loads only at frame end,
    // including an edge detected on that same cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pending    <= '0;
            pat_active <= '0;
        end else begin
            pending <= pending_nxt;
            if (frame_end) begin
                pat_active <= pending_nxt;
            end
        end
    end

    // Pixel colour and sync decode from the current counter state.
    always_comb begin
        active = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
        in_hs  = (h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END);
        in_vs  = (v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END);
        pix_r  = '0;
        pix_g  = '0;
        pix_b  = '0;
        case (pat_active)
            3'd0: begin
                pix_r = gray_idx;
                pix_g = gray_idx;
                pix_b = gray_idx;
            end
            3'd1: begin
                pix_r = MAXV;
            end
            3'd2: begin
                pix_r = MAXV;
                pix_g = MAXV;
                pix_b = MAXV;
            end
            3'd3: begin
                // white, yellow, cyan, green, magenta, red, blue, black
                pix_r = bar_idx[1] ? '0 : MAXV;
                pix_g = bar_idx[2] ? '0 : MAXV;
                pix_b = bar_idx[0] ? '0 : MAXV;
            end
`ifdef VGA_PAT_CHECKER_EN
            3'd4: begin
                if (h_cnt[CHECK_LOG2] ^ v_cnt[CHECK_LOG2]) begin
                    pix_r = MAXV;
                    pix_g = MAXV;
                    pix_b = MAXV;
                end
            end
`endif
            default: begin
                pix_r = '0;
                pix_g = '0;
                pix_b = '0;
            end
        endcase
    end

    // Output registers: one clock after counter state, all aligned.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hs          <= ~POL_HIGH;
            vs          <= ~POL_HIGH;
            blank_n     <= 1'b0;
            r           <= '0;
            g           <= '0;
            b           <= '0;
            frame_start <= 1'b0;
            pattern     <= '0;
        end else begin
            hs          <= POL_HIGH ? in_hs : ~in_hs;
            vs          <= POL_HIGH ? in_vs : ~in_vs;
            blank_n     <= active;
            r           <= active ? pix_r : '0;
            g           <= active ? pix_g : '0;
            b           <= active ? pix_b : '0;
            frame_start <= (h_cnt == '0) && (v_cnt == '0);
            pattern     <= pat_active;
        end
    end

endmodule
